// File: rtl/mux_scan_n1_if.sv
// Bus bundle for the registered N:1 channel multiplexer with auto-scan.
// The master drives channel data and controls; the slave (the mux) returns the
// registered sample, its validity, the channel index and the scan wrap pulse.
interface mux_scan_n1_if #(
    parameter int CH    = 8,
    parameter int WIDTH = 1,
    parameter int SEL_W = 3
);
    logic [CH*WIDTH-1:0] in;
    logic [SEL_W-1:0]    sel;
    logic                mode;
    logic                en;
    logic [WIDTH-1:0]    out;
    logic                out_valid;
    logic [SEL_W-1:0]    cur_sel;
    logic                wrap;

    modport master (
        output in,
        output sel,
        output mode,
        output en,
        input  out,
        input  out_valid,
        input  cur_sel,
        input  wrap
    );

    modport slave (
        input  in,
        input  sel,
        input  mode,
        input  en,
        output out,
        output out_valid,
        output cur_sel,
        output wrap
    );
endinterface

// File: rtl/mux_scan_n1.sv
// Registered N:1 channel multiplexer with manual select and auto-scan modes.
// In SCAN it walks channels 0..CH-1, holding each for DWELL enabled cycles, and
// pulses wrap when it rolls over from CH-1 back to 0. Every output is a flop,
// and out always carries the data of the channel reported on cur_sel.
module mux_scan_n1 #(
    parameter int CH    = 8,
    parameter int WIDTH = 1,
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_n1_if.slave   bus
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [SEL_W-1:0]    sel_p1;
    logic [WIDTH-1:0]    out_p1;
    logic                vld_p1;
    logic                wrap_p1;

    logic                man_ok;
    logic                dwell_done;
    logic                last_ch;
    logic [SEL_W-1:0]    scan_nxt;
    logic                scan_wrap;

    // Channel extraction; an index with no matching channel yields zero.
    function automatic logic [WIDTH-1:0] pick(
        input logic [CH*WIDTH-1:0] data,
        input logic [SEL_W-1:0]    idx
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            if (idx == SEL_W'(k)) begin
                r = data[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // Manual-select legality and the scan step (next channel and rollover).
    always_comb begin
        man_ok     = (32'(bus.sel) < CH);
        dwell_done = (cnt == CNT_W'(DWELL - 1));
        last_ch    = (sel_p1 == SEL_W'(CH - 1));
        scan_nxt   = sel_p1;
        scan_wrap  = 1'b0;
        if (dwell_done) begin
            if (last_ch) begin
                scan_nxt  = '0;
                scan_wrap = 1'b1;
            end else begin
                scan_nxt  = sel_p1 + SEL_W'(1);
            end
        end
    end

    // Mode FSM with registered sample, index, valid and wrap outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MANUAL;
            cnt     <= '0;
            sel_p1  <= '0;
            out_p1  <= '0;
            vld_p1  <= 1'b0;
            wrap_p1 <= 1'b0;
        end else if (!bus.en) begin
            // Frozen: data, index, state and dwell hold; flags drop.
            vld_p1  <= 1'b0;
            wrap_p1 <= 1'b0;
        end else if (!bus.mode) begin
            // Manual (also the immediate SCAN -> MANUAL exit).
            state   <= MANUAL;
            cnt     <= '0;
            sel_p1  <= bus.sel;
            out_p1  <= man_ok ? pick(bus.in, bus.sel) : '0;
            vld_p1  <= man_ok;
            wrap_p1 <= 1'b0;
        end else if (state == MANUAL) begin
            // Scan entry: restart at channel 0 with a full dwell.
            state   <= SCAN;
            cnt     <= '0;
            sel_p1  <= '0;
            out_p1  <= pick(bus.in, '0);
            vld_p1  <= 1'b1;
            wrap_p1 <= 1'b0;
        end else begin
            state   <= SCAN;
            cnt     <= dwell_done ? '0 : cnt + CNT_W'(1);
            sel_p1  <= scan_nxt;
            out_p1  <= pick(bus.in, scan_nxt);
            vld_p1  <= 1'b1;
            wrap_p1 <= scan_wrap;
        end
    end

    assign bus.out       = out_p1;
    assign bus.out_valid = vld_p1;
    assign bus.cur_sel   = sel_p1;
    assign bus.wrap      = wrap_p1;

`ifndef SYNTHESIS
    a_wrap_at_zero : assert property (@(posedge clk) disable iff (rst)
        bus.wrap |-> (bus.cur_sel == '0 && bus.out_valid));
    a_valid_legal : assert property (@(posedge clk) disable iff (rst)
        bus.out_valid |-> (32'(bus.cur_sel) < CH));
`endif

endmodule

// File: tb/tb_mux_scan_n1.sv
// Bench for mux_scan_n1: two instances (CH=8/WIDTH=1/DWELL=2 and
// CH=6/WIDTH=3/DWELL=1) share controls. A stimulus process pushes expected
// responses from a cycle-level behavioural model; a monitor pops and compares.
module tb_mux_scan_n1;

    typedef struct packed {
        logic [7:0] out;
        logic       vld;
        logic [2:0] sel;
        logic       wrp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    mux_scan_n1_if #(.CH(8), .WIDTH(1), .SEL_W(3)) ifa ();
    mux_scan_n1_if #(.CH(6), .WIDTH(3), .SEL_W(3)) ifb ();

    mux_scan_n1 #(.CH(8), .WIDTH(1), .SEL_W(3), .DWELL(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    mux_scan_n1 #(.CH(6), .WIDTH(3), .SEL_W(3), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: scanning flag, enabled cycles since scan entry, held outputs.
    bit         m_scan[2];
    int         m_t[2];
    logic [7:0] m_out[2];
    logic [2:0] m_sel[2];

    function automatic logic [7:0] chan(input logic [63:0] data, input int k, input int w);
        logic [63:0] v;
        v = (data >> (k * w)) & ((64'd1 << w) - 64'd1);
        return v[7:0];
    endfunction

    task automatic model_step(input int id, input int ch, input int dw, input int w,
                              input logic [63:0] data, input logic r, input logic e,
                              input logic m, input logic [2:0] s, output exp_t x);
        x.vld = 1'b0;
        x.wrp = 1'b0;
        if (r) begin
            m_scan[id] = 1'b0;
            m_t[id]    = 0;
            m_out[id]  = '0;
            m_sel[id]  = '0;
        end else if (!e) begin
            // hold everything
        end else if (!m) begin
            m_scan[id] = 1'b0;
            m_t[id]    = 0;
            m_sel[id]  = s;
            if (int'(s) < ch) begin
                m_out[id] = chan(data, int'(s), w);
                x.vld     = 1'b1;
            end else begin
                m_out[id] = '0;
            end
        end else begin
            if (!m_scan[id]) begin
                m_scan[id] = 1'b1;
                m_t[id]    = 0;
            end else begin
                m_t[id]    = m_t[id] + 1;
            end
            m_sel[id] = 3'((m_t[id] / dw) % ch);
            m_out[id] = chan(data, (m_t[id] / dw) % ch, w);
            x.vld     = 1'b1;
            x.wrp     = (m_t[id] != 0) && ((m_t[id] % (dw * ch)) == 0);
        end
        x.out = m_out[id];
        x.sel = m_sel[id];
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic m, input logic [2:0] s,
                         input logic [7:0] da, input logic [17:0] db);
        exp_t x;
        rst      = r;
        ifa.en   = e;  ifa.mode = m;  ifa.sel = s;  ifa.in = da;
        ifb.en   = e;  ifb.mode = m;  ifb.sel = s;  ifb.in = db;
        model_step(0, 8, 2, 1, {56'd0, da}, r, e, m, s, x);
        qa.push_back(x);
        model_step(1, 6, 1, 3, {46'd0, db}, r, e, m, s, x);
        qb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every edge, compare registered outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a.out",       {7'd0, ifa.out},       e.out);
                chk("a.out_valid", {7'd0, ifa.out_valid}, {7'd0, e.vld});
                chk("a.cur_sel",   {5'd0, ifa.cur_sel},   {5'd0, e.sel});
                chk("a.wrap",      {7'd0, ifa.wrap},      {7'd0, e.wrp});
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b.out",       {5'd0, ifb.out},       e.out);
                chk("b.out_valid", {7'd0, ifb.out_valid}, {7'd0, e.vld});
                chk("b.cur_sel",   {5'd0, ifb.cur_sel},   {5'd0, e.sel});
                chk("b.wrap",      {7'd0, ifb.wrap},      {7'd0, e.wrp});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [17:0] rb;
        bit          mode_r;
        int          wait_cnt;

        // Reset
        cycle(1, 1, 0, 3'd0, 8'h00, 18'd0);
        cycle(1, 1, 1, 3'd5, 8'hFF, 18'h3FFFF);

        // Manual sweep
        cycle(0, 1, 0, 3'd0, 8'b10101010, 18'o123456);
        cycle(0, 1, 0, 3'd4, 8'b01010101, 18'o654321);
        cycle(0, 1, 0, 3'd3, 8'b00001111, 18'o701234);
        cycle(0, 1, 0, 3'd5, 8'b11110000, 18'o077770);

        // Illegal selects for the 6-channel instance, then a legal one
        cycle(0, 1, 0, 3'd7, 8'b10000000, 18'o777777);
        cycle(0, 1, 0, 3'd6, 8'b01000000, 18'o777777);
        cycle(0, 1, 0, 3'd2, 8'b00000100, 18'o000700);

        // Full scan with rollover
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 3'd6, 8'b11001100, 18'o543210);

        // Restart scan, reach cur_sel=3 mid-dwell, freeze, resume
        cycle(0, 1, 0, 3'd1, 8'b11001100, 18'o543210);
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 3'd0, 8'b11001100, 18'o543210);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3'd0, 8'b00110011, 18'o012345);
        for (int i = 0; i < 2; i++) cycle(0, 1, 1, 3'd0, 8'b11001100, 18'o543210);

        // Advance to cur_sel=5, drop to manual, then re-enter scan
        for (int i = 0; i < 2; i++) cycle(0, 1, 1, 3'd0, 8'b10100101, 18'o246135);
        cycle(0, 1, 0, 3'd2, 8'b00000100, 18'o000500);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 3'd7, 8'b00000011, 18'o531642);

        // Reset mid-scan, then manual
        cycle(0, 1, 0, 3'd0, 8'h00, 18'd0);
        for (int i = 0; i < 13; i++) cycle(0, 1, 1, 3'd0, 8'b01000000, 18'o123456);
        cycle(1, 1, 1, 3'd0, 8'hFF, 18'o777777);
        cycle(0, 1, 0, 3'd6, 8'b01000000, 18'o777777);
        cycle(0, 1, 0, 3'd1, 8'b00000010, 18'o000020);

        // Randomized traffic
        mode_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mode_r = ~mode_r;
            rb = 18'($urandom);
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 7) != 0),
                  mode_r,
                  3'($urandom_range(0, 7)),
                  8'($urandom),
                  rb);
        end

        // Drain
        wait_cnt = 0;
        while ((qa.size() > 0 || qb.size() > 0) && wait_cnt < 10) begin
            @(posedge clk);
            #2;
            wait_cnt++;
        end
        if (qa.size() > 0 || qb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
